banco_registradores_param: RTL
==============================

BANCO_REGISTRADORES_PARAM -- requirements
Module: banco_registradores_param

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning):
- DATA_WIDTH, 16, register width in bits.
- ADDR_WIDTH, 3, index width; DEPTH = 2**ADDR_WIDTH registers.
- ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes and reserves.
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports.

REQ-002 The module SHALL have these ports (name, direction, width, meaning):
- clock, in, 1, single clock, rising edge.
- reset, in, 1, synchronous, active-high.
- Read1, in, ADDR_WIDTH, read index, port 1.
- Read2, in, ADDR_WIDTH, read index, port 2.
- WriteReg, in, ADDR_WIDTH, write index.
- WriteData, in, DATA_WIDTH, write data.
- RegWrite, in, 1, write enable.
- Reserve, in, 1, mark ReserveReg as pending (result outstanding).
- ReserveReg, in, ADDR_WIDTH, index to reserve.
- Data1, out, DATA_WIDTH, read data, port 1.
- Data2, out, DATA_WIDTH, read data, port 2.
- Busy1, out, 1, Read1 is pending.
- Busy2, out, 1, Read2 is pending.
- ReserveErr, out, 1, registered pulse: reserve hit an already-pending register.
- PendingCount, out, ADDR_WIDTH+1, number of pending registers.

REQ-003 The design SHALL use one clock (clock); reset is synchronous and active-high (reset); all state SHALL update only on the rising edge of clock.

Function
REQ-004 Storage SHALL be DEPTH registers of DATA_WIDTH bits, plus one pending bit per register.
REQ-005 Writes: when RegWrite=1, the register at WriteReg SHALL take WriteData at the next rising edge.
REQ-006 Reads SHALL be combinational. Data1 = reg[Read1] and Data2 = reg[Read2], with zero cycles of latency.
REQ-007 With BYPASS=1, when RegWrite=1 and WriteReg equals ReadN, DataN SHALL equal WriteData in that same cycle. With BYPASS=0, DataN SHALL show the old value until the edge.
REQ-008 With ZERO_REG=1, index 0 SHALL always read 0. Writes and reserves to index 0 SHALL be ignored, and pending[0] SHALL stay 0.
REQ-009 Reserve: when Reserve=1, pending[ReserveReg] SHALL be set at the next edge.
REQ-010 Release: when RegWrite=1, pending[WriteReg] SHALL be cleared at the next edge.
REQ-011 When Reserve=1 and RegWrite=1 target the same index in one cycle, the reserve SHALL win. The pending bit ends at 1, the data is written, and ReserveErr is not raised.
REQ-012 When Reserve=1 targets a register that is already pending (and not released in the same cycle), ReserveErr SHALL be 1 for exactly the following cycle. The pending bit stays 1.
REQ-013 BusyN SHALL equal pending[ReadN], except that it SHALL be 0 when BYPASS=1, RegWrite=1 and WriteReg equals ReadN. In that case the forwarded data is valid.
REQ-014 PendingCount SHALL be the registered population count of the pending bits and SHALL change in the same cycle as the pending bits. It never exceeds DEPTH (DEPTH-1 with ZERO_REG=1).
REQ-015 Both read ports SHALL be fully independent. Read1 and Read2 may be equal, and either may equal WriteReg.

Reset
REQ-016 While reset=1 at a rising edge, the following SHALL be 0 after that edge: all registers, all pending bits, ReserveErr and PendingCount.
REQ-017 reset SHALL take priority over RegWrite and Reserve in the same cycle. The write and the reserve are discarded.
REQ-018 After reset, Data1, Data2, Busy1 and Busy2 SHALL read 0 for every index until the first write or reserve.

Verification
REQ-019 Defaults; write 16'hABCD to reg 5; next cycle Read1=5 and Read2=5 -> Data1 = Data2 = 16'hABCD.
REQ-020 Defaults; RegWrite=1, WriteReg=3, WriteData=16'h1234, Read1=3 in the same cycle -> Data1=16'h1234 combinationally. Repeat with BYPASS=0 -> Data1=0 until the edge.
REQ-021 Reserve reg 2; next cycle Read2=2 -> Busy2=1 and PendingCount=1. Then write reg 2 -> Busy2=0 in the write cycle, and PendingCount=0 after the edge.
REQ-022 Reserve reg 4 twice on consecutive cycles -> ReserveErr=1 for the single cycle after the second reserve, and PendingCount stays 1. Reserve plus write to reg 4 in one cycle -> ReserveErr=0 and pending stays 1.
REQ-023 ZERO_REG=1; write 16'hFFFF to reg 0 and reserve reg 0 -> Data1=0, Busy1=0, PendingCount=0.
REQ-024 Reserve regs 1, 6 and 7, then write reg 1 together with reset=1 -> all of the following are 0 after the edge:
- PendingCount and all Busy outputs.
- All register contents, including reg 1 (the write is discarded).

Source files
------------

// File: rtl/banco_registradores_param.sv
// -----------------------------------------------------------------------------
// banco_registradores_param
//   Register file with two combinational read ports and one write port. Each
//   register carries a pending (scoreboard) bit. Reserve marks a register as
//   waiting for a result, and a write clears that mark. Optional features:
//   write-to-read forwarding (BYPASS) and a hardwired zero register (ZERO_REG).
//
// Parameters
//   DATA_WIDTH  register width
//   ADDR_WIDTH  index width, DEPTH = 2**ADDR_WIDTH
//   ZERO_REG    1: index 0 reads 0 and ignores writes/reserves
//   BYPASS      1: same-cycle write data is forwarded to the read ports
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   Read1/Read2         read indices
//   Data1/Data2         read data (combinational)
//   Busy1/Busy2         read index is pending (cleared by a forwarded write)
//   WriteReg/WriteData  write index/data, qualified by RegWrite
//   Reserve/ReserveReg  mark ReserveReg pending at the next edge
//   ReserveErr          one-cycle registered pulse: reserve hit a pending reg
//   PendingCount        registered count of pending registers
// -----------------------------------------------------------------------------

// One register plus its pending bit. The write/reserve enables arrive already
// decoded and masked, so this cell carries no addressing logic.
module banco_reg_cell #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic                  rsv_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  pend_o,
    output logic                  pend_d_o
);
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  pend_q, pend_d;

    always_comb begin
        data_d = data_q;
        pend_d = pend_q;
        if (we_i) begin
            data_d = wdata_i;
            pend_d = 1'b0;
        end
        // Reserve is evaluated last so it wins over a release to the same reg.
        if (rsv_i) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_q <= '0;
            pend_q <= 1'b0;
        end else begin
            data_q <= data_d;
            pend_q <= pend_d;
        end
    end

    assign data_o   = data_q;
    assign pend_o   = pend_q;
    assign pend_d_o = pend_d;
endmodule

module banco_registradores_param #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int ZERO_REG   = 0,
    parameter int BYPASS     = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] Read1,
    input  logic [ADDR_WIDTH-1:0] Read2,
    input  logic [ADDR_WIDTH-1:0] WriteReg,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RegWrite,
    input  logic                  Reserve,
    input  logic [ADDR_WIDTH-1:0] ReserveReg,
    output logic [DATA_WIDTH-1:0] Data1,
    output logic [DATA_WIDTH-1:0] Data2,
    output logic                  Busy1,
    output logic                  Busy2,
    output logic                  ReserveErr,
    output logic [ADDR_WIDTH:0]   PendingCount
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] regs;
    logic [DEPTH-1:0]                 we_vec, rsv_vec, pend_q_vec, pend_d_vec;
    logic                             we_ok, rsv_ok;
    logic                             err_q, err_d;
    logic [CW-1:0]                    cnt_q, cnt_d;

    // With ZERO_REG, accesses to index 0 are dropped here, so register 0 and
    // its pending bit never leave their reset value.
    assign we_ok  = RegWrite && !((ZERO_REG != 0) && (WriteReg   == '0));
    assign rsv_ok = Reserve  && !((ZERO_REG != 0) && (ReserveReg == '0));

    for (genvar g = 0; g < DEPTH; g++) begin : g_reg
        assign we_vec[g]  = we_ok  && (WriteReg   == ADDR_WIDTH'(g));
        assign rsv_vec[g] = rsv_ok && (ReserveReg == ADDR_WIDTH'(g));

        banco_reg_cell #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_cell (
            .clock    (clock),
            .reset    (reset),
            .we_i     (we_vec[g]),
            .rsv_i    (rsv_vec[g]),
            .wdata_i  (WriteData),
            .data_o   (regs[g]),
            .pend_o   (pend_q_vec[g]),
            .pend_d_o (pend_d_vec[g])
        );
    end

    // Double reserve is an error unless the same cycle also releases that reg.
    always_comb begin
        err_d = rsv_ok && pend_q_vec[ReserveReg]
                && !(RegWrite && (WriteReg == ReserveReg));
    end

    // Count from the next-state pending bits so the count register moves on
    // the same edge as the bits themselves.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + CW'(pend_d_vec[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign ReserveErr   = err_q;
    assign PendingCount = cnt_q;

    // Forwarding applies only to a write that will actually land.
    function automatic logic fwd_hit(input logic [ADDR_WIDTH-1:0] idx,
                                     input logic                  we,
                                     input logic [ADDR_WIDTH-1:0] widx);
        return (BYPASS != 0) && we && (widx == idx);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rd_data(
        input logic [ADDR_WIDTH-1:0]          idx,
        input logic [DEPTH-1:0][DATA_WIDTH-1:0] r,
        input logic                           fwd,
        input logic [DATA_WIDTH-1:0]          wdata);
        logic [DATA_WIDTH-1:0] d;
        d = r[idx];
        if (fwd) d = wdata;
        if ((ZERO_REG != 0) && (idx == '0)) d = '0;
        return d;
    endfunction

    logic fwd1, fwd2;

    always_comb begin
        fwd1  = fwd_hit(Read1, we_ok, WriteReg);
        fwd2  = fwd_hit(Read2, we_ok, WriteReg);
        Data1 = rd_data(Read1, regs, fwd1, WriteData);
        Data2 = rd_data(Read2, regs, fwd2, WriteData);
        // A forwarded write delivers the awaited result, so the reader is not
        // stalled on it.
        Busy1 = pend_q_vec[Read1] && !fwd1;
        Busy2 = pend_q_vec[Read2] && !fwd2;
    end
endmodule
